// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: tracks in-flight destinations for DEPTH post-ID
// stages, produces a combinational stall and registered EXE-stage forwarding
// selects for NUM_SRC source operands.
module fwd_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          forwarding_en,
  input  logic                          freeze,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic                          id_wb_en,
  input  logic                          id_mem_read,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  output logic                          hazard_stall,
  output logic [NUM_SRC*$clog2(DEPTH)-1:0] ex_sel,
  output logic                          ex_forwarded
);

  localparam int SEL_W = $clog2(DEPTH);

  // Entry k: k = 0 is the instruction in EXE, k = DEPTH-1 the oldest (WB).
  logic [DEPTH-1:0]      valid_reg;
  logic [DEPTH-1:0]      wb_en_reg;
  logic [DEPTH-1:0]      mem_read_reg;
  logic [REG_ADDR_W-1:0] dest_reg [DEPTH];

  logic [NUM_SRC*SEL_W-1:0] sel_comb;
  logic [NUM_SRC-1:0]       hit_k0;
  logic [NUM_SRC-1:0]       hit_any;
  logic                     stall_raw;
  logic                     issue;

  // The retiring entry is writing the register file, so it is never compared.
  logic unused_tail;
  assign unused_tail = ^{valid_reg[DEPTH-1], wb_en_reg[DEPTH-1],
                         mem_read_reg[DEPTH-1], dest_reg[DEPTH-1]};

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [DEPTH-2:0] hit;
    logic [SEL_W-1:0] code;

    for (genvar gk = 0; gk < DEPTH-1; gk++) begin : g_stage
      assign hit[gk] = id_src_used[gi] && valid_reg[gk] && wb_en_reg[gk] &&
                       (dest_reg[gk] == id_src[gi*REG_ADDR_W +: REG_ADDR_W]);
    end

    // Youngest match wins: scan oldest to youngest so the lowest k is kept.
    always_comb begin
      code = '0;
      for (int k = DEPTH-2; k >= 0; k--) begin
        if (hit[k]) code = SEL_W'(k + 1);
      end
    end

    assign sel_comb[gi*SEL_W +: SEL_W] = forwarding_en ? code : '0;
    assign hit_k0[gi]  = hit[0];
    assign hit_any[gi] = |hit;
  end

  // Load-use stalls in forwarding mode; any in-flight producer stalls otherwise.
  always_comb begin
    if (forwarding_en) stall_raw = id_valid && (|hit_k0) && mem_read_reg[0];
    else               stall_raw = id_valid && (|hit_any);
  end

  assign hazard_stall = !rst && stall_raw;
  assign issue        = id_valid && !stall_raw && !flush;

  // Advance the destination record and register the EXE-stage selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      wb_en_reg    <= '0;
      mem_read_reg <= '0;
      for (int k = 0; k < DEPTH; k++) dest_reg[k] <= '0;
      ex_sel       <= '0;
      ex_forwarded <= 1'b0;
    end else if (!freeze) begin
      valid_reg    <= {valid_reg[DEPTH-2:0], issue};
      wb_en_reg    <= {wb_en_reg[DEPTH-2:0], issue && id_wb_en};
      mem_read_reg <= {mem_read_reg[DEPTH-2:0], issue && id_mem_read};
      dest_reg[0]  <= issue ? id_dest : '0;
      for (int k = 1; k < DEPTH; k++) dest_reg[k] <= dest_reg[k-1];
      ex_sel       <= issue ? sel_comb : '0;
      ex_forwarded <= issue && (|sel_comb);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized bench for fwd_scoreboard against a pipeline-level reference model.
module tb_fwd_scoreboard;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int D  = 3;
  localparam int SW = $clog2(D);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, forwarding_en, freeze, flush;
  logic           id_valid, id_wb_en, id_mem_read;
  logic [W-1:0]   id_dest;
  logic [N*W-1:0] id_src;
  logic [N-1:0]   id_src_used;
  logic           hazard_stall;
  logic [N*SW-1:0] ex_sel;
  logic           ex_forwarded;

  fwd_scoreboard #(.REG_ADDR_W(W), .NUM_SRC(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .forwarding_en(forwarding_en), .freeze(freeze),
    .flush(flush), .id_valid(id_valid), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .id_src(id_src),
    .id_src_used(id_src_used), .hazard_stall(hazard_stall),
    .ex_sel(ex_sel), .ex_forwarded(ex_forwarded)
  );

  typedef struct {
    bit         v;
    bit         wb;
    bit         mr;
    bit [W-1:0] d;
  } ent_t;

  ent_t        pipe [D];   // pipe[0] = EXE, pipe[D-1] = WB
  bit [N*SW-1:0] exp_sel;
  bit          exp_fwd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stage index of the youngest live writer of r among comparable stages, or -1.
  function automatic int youngest(input bit [W-1:0] r);
    for (int k = 0; k <= D-2; k++)
      if (pipe[k].v && pipe[k].wb && pipe[k].d == r) return k;
    return -1;
  endfunction

  initial begin
    bit            exp_stall;
    bit [N*SW-1:0] sel_now;
    bit            iss;
    int            y;

    rst = 1'b1; forwarding_en = 1'b1; freeze = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_wb_en = 1'b1; id_mem_read = 1'b1;
    id_dest = '0; id_src = '0; id_src_used = '1;
    for (int k = 0; k < D; k++) pipe[k] = '{1'b0, 1'b0, 1'b0, '0};
    exp_sel = '0; exp_fwd = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_sel", 32'(ex_sel), 32'd0);
    chk("rst_ex_fwd", 32'(ex_forwarded), 32'd0);
    chk("rst_stall", 32'(hazard_stall), 32'd0);

    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 99) < 3);
      freeze        = ($urandom_range(0, 99) < 10);
      flush         = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 5) forwarding_en = ~forwarding_en;
      id_valid      = ($urandom_range(0, 99) < 85);
      id_wb_en      = ($urandom_range(0, 99) < 75);
      id_mem_read   = ($urandom_range(0, 99) < 35);
      id_dest       = W'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) id_src[i*W +: W] = W'($urandom_range(0, 3));
      id_src_used   = N'($urandom);
      #1;

      // Expected stall and selects straight from the matching rules.
      exp_stall = 1'b0;
      sel_now   = '0;
      for (int i = 0; i < N; i++) begin
        y = id_src_used[i] ? youngest(id_src[i*W +: W]) : -1;
        if (y >= 0) begin
          if (forwarding_en) begin
            sel_now[i*SW +: SW] = SW'(y + 1);
            if (y == 0 && pipe[0].mr) exp_stall = 1'b1;
          end else begin
            exp_stall = 1'b1;
          end
        end
      end
      exp_stall = exp_stall && id_valid && !rst;
      chk("stall", 32'(hazard_stall), 32'(exp_stall));
      iss = id_valid && !exp_stall && !flush;

      @(posedge clk);
      #1;
      if (rst) begin
        for (int k = 0; k < D; k++) pipe[k] = '{1'b0, 1'b0, 1'b0, '0};
        exp_sel = '0;
        exp_fwd = 1'b0;
      end else if (!freeze) begin
        for (int k = D-1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = iss ? '{1'b1, id_wb_en, id_mem_read, id_dest}
                      : '{1'b0, 1'b0, 1'b0, '0};
        exp_sel = iss ? sel_now : '0;
        exp_fwd = iss && (sel_now != '0);
      end
      chk("ex_sel", 32'(ex_sel), 32'(exp_sel));
      chk("ex_fwd", 32'(ex_forwarded), 32'(exp_fwd));
      $display("cyc=%0d rst=%b frz=%b fl=%b fe=%b v=%b stall=%b ex_sel=%h fwd=%b",
               cyc, rst, freeze, flush, forwarding_en, id_valid,
               hazard_stall, ex_sel, ex_forwarded);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the ARM pipeline.
- Keeps its own shift-register record of in-flight destinations for DEPTH post-ID stages (default EXE/MEM/WB). It compares every ID-stage source operand against that record and produces registered EXE-stage forwarding selects for NUM_SRC operands.
- Also raises a combinational load-use/no-forward stall toward the hazard/IF-ID logic.
- Sits between the ID stage and the EXE-stage operand muxes.

Parameters:
- REG_ADDR_W, 4, register address width
- NUM_SRC, 3, source operands per instruction (Rn, Rm, Rs)
- DEPTH, 3, tracked post-ID stages; must be ≥ 2
- SEL_W, $clog2(DEPTH), width of one select field (derived, localparam)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- forwarding_en  in  1  1 = forwarding mode, 0 = stall-only mode
- freeze  in  1  whole-pipe hold (e.g. memory wait)
- flush  in  1  kill the ID instruction (branch taken)
- id_valid  in  1  ID holds a real instruction
- id_wb_en  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- id_dest  in  REG_ADDR_W  ID destination
- id_src  in  NUM_SRC*REG_ADDR_W  ID sources; operand i occupies bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NUM_SRC  per-operand valid mask
- hazard_stall  out  1  hold IF/ID, insert bubble (combinational)
- ex_sel  out  NUM_SRC*SEL_W  registered EXE-stage selects; field i at [i*SEL_W +: SEL_W]
- ex_forwarded  out  1  registered; any ex_sel field nonzero

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- State: entries e[0..DEPTH-1], each holding {valid, wb_en, mem_read, dest}.
  - e[0] = instruction now in EXE; e[DEPTH-1] = oldest (WB).
  - An entry is live iff valid && wb_en.
- Reset: all entries cleared. ex_sel = 0, ex_forwarded = 0. hazard_stall forced to 0 while rst = 1.
- Match: operand i matches stage k iff id_src_used[i] && e[k] live && e[k].dest == operand i.
  - Only k in 0..DEPTH-2 is checked. e[DEPTH-1] is writing the register file and is not matched.
- Stall, forwarding_en = 1: hazard_stall = 1 iff id_valid && any operand matches k = 0 && e[0].mem_read.
- Stall, forwarding_en = 0: hazard_stall = 1 iff id_valid && any operand matches any k in 0..DEPTH-2.
- Select code, per operand, computed combinationally:
  - 0 = register file.
  - k+1 = forward from the stage that e[k] will occupy next cycle (DEPTH=3: 1 = MEM, 2 = WB).
  - When several stages match, the youngest (lowest k) wins.
  - All codes are 0 when forwarding_en = 0.
- Advance rule, evaluated each rising edge, priority top-down:
  1. rst: clear as above.
  2. freeze: all state and outputs hold. flush and issue are ignored; upstream holds flush until freeze drops.
  3. Otherwise: e[k+1] <= e[k] for k = 0..DEPTH-2, and e[DEPTH-1] retires.
     - e[0] <= ID fields if id_valid && !hazard_stall && !flush; else a bubble (valid = 0).
     - ex_sel and ex_forwarded load the computed selects when the instruction issues; else 0.
- Latency: selects are presented one cycle after the instruction leaves ID, aligned with its EXE cycle.
- Boundary rules:
  - Sources equal to each other or to id_dest have no special meaning.
  - dest = 0 is matched normally.
  - A match against a bubble is never made.
  - Reset mid-stall clears the stall on the next cycle.
  - flush with hazard_stall: a bubble is inserted, the same as a stall alone.
- RTL size: 120–400 lines; no latches; generate loops over NUM_SRC and DEPTH.

Test Plan:
1. ADD r1 issued, then next cycle ID SUB with src0 = r1 (forwarding_en = 1) -> hazard_stall = 0; after the edge, ex_sel field0 = 1, ex_forwarded = 1.
2. LDR r2 issued, then ID uses r2 as src1 -> hazard_stall = 1 for exactly one cycle and a bubble enters e[0]. The following cycle the ID issues with ex_sel field1 = 2 (WB).
3. r3 written by both e[0] and e[1], ID src2 = r3 -> field2 = 1 (youngest wins). With id_src_used[2] = 0 -> field2 = 0.
4. forwarding_en = 0, r4 producer in e[1], ID reads r4 -> hazard_stall = 1. Producer in e[2] only -> hazard_stall = 0 and all selects 0.
5. freeze held 3 cycles with a pending match -> entries, ex_sel and hazard_stall unchanged. flush asserted after freeze drops -> e[0] becomes a bubble and ex_sel = 0.
6. rst asserted while hazard_stall = 1 -> next cycle all entries invalid, ex_sel = 0, ex_forwarded = 0, hazard_stall = 0.
